// File: rtl/hazard_unit_pkg.sv
// Shared core constants: register index width and the EX operand mux3
// select encoding used by both the hazard unit and the mux3 decode.
package hazard_unit_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter for debug event counts; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step on an event unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core: operand forwarding
// selects, load-use stall, branch flush and debug event counters.
module hazard_unit #(
    parameter int REG_ADDR_W = hazard_unit_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  regwrite_d,
    input  logic                  is_load_d,
    input  logic                  pc_src_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    import hazard_unit_pkg::*;

    logic [REG_ADDR_W-1:0] rs1_e_q, rs1_e_d;
    logic [REG_ADDR_W-1:0] rs2_e_q, rs2_e_d;
    logic [REG_ADDR_W-1:0] rd_e_q, rd_e_d;
    logic                  regwrite_e_q, regwrite_e_d;
    logic                  is_load_e_q, is_load_e_d;
    logic [REG_ADDR_W-1:0] rd_m_q;
    logic                  regwrite_m_q;
    logic [REG_ADDR_W-1:0] rd_w_q;
    logic                  regwrite_w_q;
    logic                  lwstall;

    assign lwstall = is_load_e_q && (rd_e_q != '0) &&
                     ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));

    // Control outputs; a taken branch overrides the stall because the
    // stalled instruction is on the wrong path. Forced low while in reset.
    assign stall_f = !rst && lwstall && !pc_src_e;
    assign stall_d = stall_f;
    assign flush_d = !rst && pc_src_e;
    assign flush_e = !rst && (lwstall || pc_src_e);

    // E-stage next value: capture the D instruction or insert a bubble.
    always_comb begin
        rs1_e_d      = rs1_d;
        rs2_e_d      = rs2_d;
        rd_e_d       = rd_d;
        regwrite_e_d = regwrite_d;
        is_load_e_d  = is_load_d;
        if (flush_e) begin
            rs1_e_d      = '0;
            rs2_e_d      = '0;
            rd_e_d       = '0;
            regwrite_e_d = 1'b0;
            is_load_e_d  = 1'b0;
        end
    end

    // Shadow pipeline registers E -> M -> W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_e_q      <= '0;
            rs2_e_q      <= '0;
            rd_e_q       <= '0;
            regwrite_e_q <= 1'b0;
            is_load_e_q  <= 1'b0;
            rd_m_q       <= '0;
            regwrite_m_q <= 1'b0;
            rd_w_q       <= '0;
            regwrite_w_q <= 1'b0;
        end else begin
            rs1_e_q      <= rs1_e_d;
            rs2_e_q      <= rs2_e_d;
            rd_e_q       <= rd_e_d;
            regwrite_e_q <= regwrite_e_d;
            is_load_e_q  <= is_load_e_d;
            rd_m_q       <= rd_e_q;
            regwrite_m_q <= regwrite_e_q;
            rd_w_q       <= rd_m_q;
            regwrite_w_q <= regwrite_m_q;
        end
    end

    // Operand forwarding selects; MEM beats WB, x0 never forwards.
    always_comb begin
        forward_a_e = FWD_REGFILE;
        if (regwrite_m_q && (rd_m_q != '0) && (rd_m_q == rs1_e_q)) begin
            forward_a_e = FWD_MEM;
        end else if (regwrite_w_q && (rd_w_q != '0) && (rd_w_q == rs1_e_q)) begin
            forward_a_e = FWD_WB;
        end

        forward_b_e = FWD_REGFILE;
        if (regwrite_m_q && (rd_m_q != '0) && (rd_m_q == rs2_e_q)) begin
            forward_b_e = FWD_MEM;
        end else if (regwrite_w_q && (rd_w_q != '0) && (rd_w_q == rs2_e_q)) begin
            forward_b_e = FWD_WB;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_d),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_d),
        .count (flush_cnt)
    );

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RV32I core. Tracks destination registers of instructions in EX, MEM and WB, generates the 2-bit forwarding selects consumed by the EX-stage operand `mux3` instances, and detects load-use hazards (stall F/D, bubble E) and taken branches/jumps (flush D/E). It also keeps saturating stall and flush event counters for debug.

## Interface
Parameters:
- `REG_ADDR_W`, 5: register index width.
- `CNT_W`, 32: event counter width.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rs1_d`, `rs2_d`  in  `REG_ADDR_W` each  source registers of the instruction in D.
- `rd_d`  in  `REG_ADDR_W`  destination of the instruction in D.
- `regwrite_d`  in  1  the D instruction writes `rd_d`.
- `is_load_d`  in  1  the D instruction is a load (result from memory).
- `pc_src_e`  in  1  branch/jump taken, resolved in EX.
- `forward_a_e`, `forward_b_e`  out  2 each  operand selects: 00 regfile, 01 WB result, 10 MEM ALU result.
- `stall_f`, `stall_d`  out  1 each  hold the PC / IF-ID register.
- `flush_d`, `flush_e`  out  1 each  clear the IF-ID / ID-EX register.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  saturating event counters.

## Operation
- Internal shadow pipeline, all flops on `clk`:
  - E: `rs1_e`, `rs2_e`, `rd_e`, `regwrite_e`, `is_load_e`.
  - M: `rd_m`, `regwrite_m`.
  - W: `rd_w`, `regwrite_w`.
- Advance each cycle: M←E, W←M. E←D fields, unless `flush_e`=1, in which case all E fields load 0 (bubble).
- Forwarding for operand A; B is identical using `rs2_e`:
  - 10 if `regwrite_m` && `rd_m`≠0 && `rd_m`==`rs1_e`.
  - Else 01 if `regwrite_w` && `rd_w`≠0 && `rd_w`==`rs1_e`.
  - Else 00.
  - MEM has priority over WB. x0 is never forwarded. Code 11 is never driven.
- Load-use: `lwstall` = `is_load_e` && `rd_e`≠0 && (`rd_e`==`rs1_d` || `rd_e`==`rs2_d`).
- Control outputs:
  - `stall_f` = `stall_d` = `lwstall` && !`pc_src_e`.
  - `flush_d` = `pc_src_e`.
  - `flush_e` = `lwstall` || `pc_src_e`.
- Simultaneous load-use and taken branch: the branch wins. No stall; D and E are flushed because the stalled instruction is on the wrong path.
- Counters:
  - `stall_cnt` increments on each cycle with `stall_d`=1.
  - `flush_cnt` increments on each cycle with `flush_d`=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset: all internal flops, both counters and all outputs are 0 (`forward_*`=00, stalls and flushes 0). Takes effect immediately (asynchronous). Release is synchronous to the next `clk` edge from the core's point of view.
- All outputs are combinational from registered state plus the current D/EX inputs, valid in the same cycle. Zero-cycle latency to the `mux3` selects.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in M with `is_load` cleared from E, and the dependent instruction forwards from WB one cycle later (01).
- Reset mid-stall drops every output to 0 at once. There are no pending states to replay.
- Counters update on the edge following the event cycle.

## Structure
- Shared core package: `FWD_REGFILE`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10, and `REG_ADDR_W`. The `mux3` select decode and this unit use the same constants.
- One natural sub-module: `sat_counter` (width parameter, `inc` input), instantiated twice.
- Forward-select logic is duplicated inline for A and B. No further sub-modules.

## Test plan
- Reset asserted mid-run with non-zero counters: all outputs and counters read 0 in the same cycle.
- `add x5` then `sub` using `rs1`=x5 on the next cycle: `forward_a_e`=10 in the `sub` EX cycle. With one instruction between them: `forward_a_e`=01.
- Instructions in both M and W write x5 and EX reads x5 on `rs2`: `forward_b_e`=10 (MEM priority). Repeat with x0 as destination: `forward_b_e`=00.
- `lw x6` in EX while D reads x6: `stall_f`=`stall_d`=`flush_e`=1 for one cycle. The next EX cycle shows `forward_*`=01 and `stall_cnt` increments by 1.
- Load-use and `pc_src_e`=1 in the same cycle: `stall_*`=0, `flush_d`=`flush_e`=1, `flush_cnt`+1, `stall_cnt` unchanged.
- Force `stall_cnt` to all-ones with `CNT_W`=4 over 20 stalls: the counter holds at 15.
